adv_pixel_serializer: RTL and testbench
=======================================

ADV_PIXEL_SERIALIZER -- requirements
Module: adv_pixel_serializer

Interface
REQ-001 Parameter PX_TO_DE, default 100, pixel enables after hsync before first active pixel.
REQ-002 Parameter PX_ACT_DE, default 1280, active pixels per line.
REQ-003 Parameter PY_TO_DE, default 5, lines after vsync before first active line.
REQ-004 Parameter PY_ACT, default 720, active lines per frame.
REQ-005 Parameters HSYNC_POL, VSYNC_POL, defaults 1'b1, output sync polarities (1 = active-high).
REQ-006 clk_out  in  1  single block clock; all logic on rising edge, no negedge logic.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pix_en  in  1  one-cycle strobe marking each pixel on data/hsync/vsync.
REQ-009 hsync, vsync  in  1 each  active-high input syncs, valid when pix_en=1.
REQ-010 data  in  24  pixel, 24 bpp.
REQ-011 mode  in  2  0 = 24-bit SDR (1 beat), 1 = 12-bit dual-beat, 2 = 8-bit triple-beat, 3 = treated as 0.
REQ-012 de_out, hsync_out, vsync_out  out  1 each  registered, aligned with data_out.
REQ-013 data_out  out  24  beat data; unused upper bits zero.
REQ-014 beat_first  out  1  high on first beat of each pixel (pixel-clock generation).
REQ-015 overrun  out  1  sticky: pixel arrived before previous pixel's beats completed.

Function
REQ-016 Active mode register loads from mode at reset and on each vsync falling edge (sampled on pix_en); mode changes mid-frame have no effect.
REQ-017 Beats per pixel: 1 (mode 0/3), 2 (mode 1), 3 (mode 2).
REQ-018 pix_en at cycle N: beat 0 on data_out at N+1, beat k at N+1+k; idle cycles after last beat hold previous sync/de values and drive data_out=0.
REQ-019 Beat order: mode 1 data[11:0] then data[23:12]; mode 2 data[7:0], [15:8], [23:16]; mode 0 data[23:0].
REQ-020 hsync_out/vsync_out = captured input XOR ~POL, held for all beats of the pixel.
REQ-021 h_count increments per pix_en; pix_en with hsync=1 loads 0; saturates at all-ones, no wrap.
REQ-022 v_count increments on hsync rising edge (pix_en-sampled); loads 0 on vsync falling edge; vsync edge wins if simultaneous; saturates.
REQ-023 Pixel active when PX_TO_DE <= h_count < PX_TO_DE+PX_ACT_DE and PY_TO_DE < v_count <= PY_TO_DE+PY_ACT; de_out=1 for all beats of an active pixel, else 0.
REQ-024 data_out = 0 whenever de_out = 0.
REQ-025 Serializer FSM: IDLE -> BEAT(k) on pix_en; BEAT(k) -> BEAT(k+1) until last beat -> IDLE; pix_en in any state restarts at BEAT(0) with new pixel.
REQ-026 pix_en while not in IDLE and not in last beat sets overrun; remaining old beats discarded.
REQ-027 Counter widths $clog2(limit)+1 of the respective totals.

Reset
REQ-028 On reset: de_out=0, data_out=0, beat_first=0, overrun=0, hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL, counters 0, FSM IDLE, mode register loaded from mode.
REQ-029 Reset mid-pixel abandons remaining beats; first output after release is beat 0 of next pix_en.

Structure
REQ-030 Mode encodings and beats-per-mode function live in shared package adv_pkg.
REQ-031 Timing counters/DE window in sub-module adv_de_gen; serializer FSM in top level.

Verification
REQ-032 Mode 1, pix_en every 2 cycles, active pixel data=24'hABC123 -> data_out 12'h123 then 12'hABC, beat_first 1 then 0, de_out 1 both beats.
REQ-033 Mode 2, data=24'h112233 -> beats 8'h33, 8'h22, 8'h11 on three consecutive cycles.
REQ-034 Default params, line 6 after vsync fall, pixel 100 -> de_out rises; pixel 1380 -> de_out 0; line 5 -> de_out 0 throughout.
REQ-035 Mode 2, pix_en every 2 cycles -> overrun=1 after second pixel, stays 1 until reset.
REQ-036 mode changed 0->1 mid-frame -> output stays 1-beat until next vsync falling edge, then 2-beat.
REQ-037 HSYNC_POL=0, hsync=1 input -> hsync_out=0; reset asserted during beat 1 -> next cycle data_out=0, de_out=0.

Source files
------------

// File: rtl/adv_pkg.sv
// Shared definitions for the ADV pixel serializer.
//   adv_mode_e     : output bus mode encodings (0 = 24-bit SDR, 1 = 12-bit dual-beat,
//                    2 = 8-bit triple-beat, 3 = reserved, behaves like 0)
//   ser_state_e    : serializer FSM states (IDLE, or which beat is on data_out)
//   beats_per_mode : number of data_out beats a pixel occupies in a given mode
//   beat_slice     : zero-extended slice of a 24-bit pixel for beat k
//   cnt_width      : width of a timing counter able to hold a given limit
package adv_pkg;

  typedef enum logic [1:0] {
    MODE_SDR24  = 2'd0,
    MODE_DUAL12 = 2'd1,
    MODE_TRI8   = 2'd2,
    MODE_RSVD   = 2'd3
  } adv_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_BEAT2
  } ser_state_e;

  function automatic logic [1:0] beats_per_mode(adv_mode_e m);
    case (m)
      MODE_DUAL12: return 2'd2;
      MODE_TRI8:   return 2'd3;
      default:     return 2'd1;
    endcase
  endfunction

  function automatic logic [23:0] beat_slice(adv_mode_e m, logic [23:0] px, logic [1:0] k);
    logic [23:0] r;
    r = '0;
    case (m)
      MODE_DUAL12: r[11:0] = (k == 2'd0) ? px[11:0] : px[23:12];
      MODE_TRI8: begin
        case (k)
          2'd0:    r[7:0] = px[7:0];
          2'd1:    r[7:0] = px[15:8];
          default: r[7:0] = px[23:16];
        endcase
      end
      default:     r = px;
    endcase
    return r;
  endfunction

  function automatic int unsigned cnt_width(int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/adv_de_gen.sv
// Horizontal/vertical pixel timing counters and data-enable window.
//   clk_i, rst_i   : block clock, synchronous active-high reset
//   pix_en_i       : pixel strobe; hsync_i/vsync_i are sampled only with it
//   active_o       : the pixel presented with pix_en_i lies inside the DE window
//   vsync_fall_o   : the pixel presented with pix_en_i is a vsync falling edge
// Counts are evaluated on the values the strobed pixel itself receives, so the
// hsync pixel is h=0 and the first line after a vsync falling edge is line 1.
module adv_de_gen
  import adv_pkg::*;
#(
  parameter int unsigned PX_TO_DE  = 100,
  parameter int unsigned PX_ACT_DE = 1280,
  parameter int unsigned PY_TO_DE  = 5,
  parameter int unsigned PY_ACT    = 720
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pix_en_i,
  input  logic hsync_i,
  input  logic vsync_i,
  output logic active_o,
  output logic vsync_fall_o
);

  localparam int unsigned H_TOT = PX_TO_DE + PX_ACT_DE;
  localparam int unsigned V_TOT = PY_TO_DE + PY_ACT;
  localparam int unsigned HW    = cnt_width(H_TOT);
  localparam int unsigned VW    = cnt_width(V_TOT);

  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          hs_prev_q, hs_prev_d;
  logic          vs_prev_q, vs_prev_d;
  logic          hs_rise, vs_fall;

  always_comb begin
    hs_rise   = pix_en_i & hsync_i & ~hs_prev_q;
    vs_fall   = pix_en_i & ~vsync_i & vs_prev_q;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    if (pix_en_i) begin
      hs_prev_d = hsync_i;
      vs_prev_d = vsync_i;
      if (hsync_i)                h_count_d = '0;
      else if (h_count_q != '1)   h_count_d = h_count_q + HW'(1);
      // vsync falling edge outranks a coincident hsync rising edge
      if (vs_fall)                             v_count_d = '0;
      else if (hs_rise && (v_count_q != '1))   v_count_d = v_count_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_count_q <= '0;
      v_count_q <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign active_o = (h_count_d >= HW'(PX_TO_DE)) && (h_count_d < HW'(H_TOT)) &&
                    (v_count_d >  VW'(PY_TO_DE)) && (v_count_d <= VW'(V_TOT));
  assign vsync_fall_o = vs_fall;

endmodule

// File: rtl/adv_pixel_serializer.sv
// Serializes 24-bit pixels onto an ADV-style video bus in 1, 2 or 3 beats.
//   clk_out, reset          : block clock, synchronous active-high reset
//   pix_en, hsync, vsync    : pixel strobe and its syncs (sampled with pix_en)
//   data[23:0], mode[1:0]   : pixel and bus mode (mode latched on vsync fall)
//   de_out, hsync_out,
//   vsync_out, data_out     : registered beat outputs, mutually aligned
//   beat_first              : high on the first beat of each pixel
//   overrun                 : sticky, a pixel arrived before the previous one finished
module adv_pixel_serializer
  import adv_pkg::*;
#(
  parameter int unsigned PX_TO_DE  = 100,
  parameter int unsigned PX_ACT_DE = 1280,
  parameter int unsigned PY_TO_DE  = 5,
  parameter int unsigned PY_ACT    = 720,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1
) (
  input  logic        clk_out,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] data,
  input  logic [1:0]  mode,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] data_out,
  output logic        beat_first,
  output logic        overrun
);

  ser_state_e  state_q, state_d;
  adv_mode_e   mode_q, mode_d;
  adv_mode_e   pmode_q, pmode_d;
  logic [23:0] pix_q, pix_d;
  logic [23:0] data_q, data_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, bf_q, bf_d, ovr_q, ovr_d;
  logic        px_active, vs_fall;
  logic [1:0]  beat_idx, beat_last;

  adv_de_gen #(
    .PX_TO_DE (PX_TO_DE),
    .PX_ACT_DE(PX_ACT_DE),
    .PY_TO_DE (PY_TO_DE),
    .PY_ACT   (PY_ACT)
  ) u_de_gen (
    .clk_i       (clk_out),
    .rst_i       (reset),
    .pix_en_i    (pix_en),
    .hsync_i     (hsync),
    .vsync_i     (vsync),
    .active_o    (px_active),
    .vsync_fall_o(vs_fall)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pmode_d  = pmode_q;
    pix_d    = pix_q;
    data_d   = '0;
    de_d     = de_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    bf_d     = 1'b0;
    ovr_d    = ovr_q;

    case (state_q)
      S_BEAT1: beat_idx = 2'd1;
      S_BEAT2: beat_idx = 2'd2;
      default: beat_idx = 2'd0;
    endcase
    beat_last = beats_per_mode(pmode_q) - 2'd1;

    // The pixel carrying the vsync falling edge already uses the newly latched mode.
    if (vs_fall) mode_d = adv_mode_e'(mode);

    if (pix_en) begin
      if ((state_q != S_IDLE) && (beat_idx != beat_last)) ovr_d = 1'b1;
      pmode_d = mode_d;
      // Blanked pixels are stored as zero so every beat of them drives zero.
      pix_d   = px_active ? data : '0;
      de_d    = px_active;
      hs_d    = hsync ^ ~HSYNC_POL;
      vs_d    = vsync ^ ~VSYNC_POL;
      bf_d    = 1'b1;
      data_d  = beat_slice(mode_d, pix_d, 2'd0);
      state_d = S_BEAT0;
    end else if (state_q != S_IDLE) begin
      if (beat_idx == beat_last) begin
        state_d = S_IDLE;
      end else begin
        state_d = (state_q == S_BEAT0) ? S_BEAT1 : S_BEAT2;
        data_d  = beat_slice(pmode_q, pix_q, beat_idx + 2'd1);
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= adv_mode_e'(mode);
      pmode_q <= MODE_SDR24;
      pix_q   <= '0;
      data_q  <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      bf_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pmode_q <= pmode_d;
      pix_q   <= pix_d;
      data_q  <= data_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      bf_q    <= bf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign de_out     = de_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign data_out   = data_q;
  assign beat_first = bf_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_adv_pixel_serializer.sv
// Self-checking bench for adv_pixel_serializer: two instances (sync polarity 1 and 0)
// share one stimulus; a queue-based pixel model is compared on every cycle and
// directed literal expectations pin the model.
module tb_adv_pixel_serializer;

  localparam int PX_TO_DE  = 100;
  localparam int PX_ACT_DE = 1280;
  localparam int PY_TO_DE  = 5;
  localparam int PY_ACT    = 720;
  localparam int HMAX      = (1 << ($clog2(PX_TO_DE + PX_ACT_DE) + 1)) - 1;
  localparam int VMAX      = (1 << ($clog2(PY_TO_DE + PY_ACT) + 1)) - 1;

  logic        clk = 1'b0;
  logic        reset, pix_en, hsync, vsync;
  logic [23:0] data;
  logic [1:0]  mode;
  logic        de1, hs1, vs1, bf1, ov1;
  logic        de2, hs2, vs2, bf2, ov2;
  logic [23:0] d1, d2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adv_pixel_serializer u_dut1 (
    .clk_out(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .data(data), .mode(mode), .de_out(de1), .hsync_out(hs1), .vsync_out(vs1),
    .data_out(d1), .beat_first(bf1), .overrun(ov1)
  );

  adv_pixel_serializer #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_dut2 (
    .clk_out(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .data(data), .mode(mode), .de_out(de2), .hsync_out(hs2), .vsync_out(vs2),
    .data_out(d2), .beat_first(bf2), .overrun(ov2)
  );

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        bf;
    logic [23:0] d;
  } beat_t;

  beat_t       q[$];
  beat_t       cur;
  beat_t       b;
  bit          m_ovr, armed, hsp, vsp, hrise, vfall, act;
  int          hc, vc, mreg, nb, bw;

  initial armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      cur   = '0;
      m_ovr = 1'b0;
      hc    = 0;
      vc    = 0;
      hsp   = 1'b0;
      vsp   = 1'b0;
      mreg  = int'(mode);
      armed = 1'b1;
    end else if (pix_en) begin
      hrise = hsync && !hsp;
      vfall = !vsync && vsp;
      hsp   = hsync;
      vsp   = vsync;
      if (hsync) hc = 0;
      else if (hc != HMAX) hc = hc + 1;
      if (vfall) begin
        vc   = 0;
        mreg = int'(mode);
      end else if (hrise && vc != VMAX) vc = vc + 1;
      act = (hc >= PX_TO_DE) && (hc < PX_TO_DE + PX_ACT_DE) &&
            (vc > PY_TO_DE) && (vc <= PY_TO_DE + PY_ACT);
      if (q.size() != 0) m_ovr = 1'b1;
      q.delete();
      nb = (mreg == 1) ? 2 : (mreg == 2) ? 3 : 1;
      bw = 24 / nb;
      for (int k = 0; k < nb; k++) begin
        b.de = act;
        b.hs = hsync;
        b.vs = vsync;
        b.bf = (k == 0);
        b.d  = act ? 24'((data >> (bw * k)) & ((32'd1 << bw) - 32'd1)) : 24'd0;
        q.push_back(b);
      end
      cur = q.pop_front();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      cur.d  = '0;
      cur.bf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("de_out",         24'(de1), 24'(cur.de));
      chk("hsync_out",      24'(hs1), 24'(cur.hs));
      chk("vsync_out",      24'(vs1), 24'(cur.vs));
      chk("data_out",       d1,       cur.d);
      chk("beat_first",     24'(bf1), 24'(cur.bf));
      chk("overrun",        24'(ov1), 24'(m_ovr));
      chk("de_out_p0",      24'(de2), 24'(cur.de));
      chk("hsync_out_p0",   24'(hs2), 24'(!cur.hs));
      chk("vsync_out_p0",   24'(vs2), 24'(!cur.vs));
      chk("data_out_p0",    d2,       cur.d);
      chk("beat_first_p0",  24'(bf2), 24'(cur.bf));
      chk("overrun_p0",     24'(ov2), 24'(m_ovr));
    end
  end

  // ---------------- stimulus ----------------
  // Presents one pixel for one cycle; on return data_out shows its beat 0.
  task automatic pix(input bit hs, input bit vs, input logic [23:0] d, input int gap);
    pix_en = 1'b1;
    hsync  = hs;
    vsync  = vs;
    data   = d;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // vsync fall, lines 1..6; the next pixel sent is h=100 on line 6.
  task automatic new_frame_to_active();
    pix(1'b0, 1'b1, 24'h0, 2);
    pix(1'b0, 1'b0, 24'h0, 2);
    for (int unsigned l = 1; l <= 6; l++) begin
      pix(1'b1, 1'b0, 24'h0, 0);
      chk("hsync_out_pol1_lit", 24'(hs1), 24'd1);
      chk("hsync_out_pol0_lit", 24'(hs2), 24'd0);
      repeat (2) @(negedge clk);
      if (l < 6) pix(1'b0, 1'b0, 24'h0, 2);
    end
    for (int unsigned h = 1; h <= 99; h++) pix(1'b0, 1'b0, 24'(h), 2);
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    data   = '0;
    mode   = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_de",       24'(de1), 24'd0);
    chk("rst_data",     d1,       24'd0);
    chk("rst_bf",       24'(bf1), 24'd0);
    chk("rst_ovr",      24'(ov1), 24'd0);
    chk("rst_hs_pol1",  24'(hs1), 24'd0);
    chk("rst_hs_pol0",  24'(hs2), 24'd1);
    chk("rst_vs_pol0",  24'(vs2), 24'd1);
    reset = 1'b0;
    @(negedge clk);

    // DE window with default timing, mode 0
    pix(1'b0, 1'b1, 24'h0, 2);
    pix(1'b0, 1'b0, 24'h0, 2);
    for (int unsigned l = 1; l <= 4; l++) begin
      pix(1'b1, 1'b0, 24'h0, 2);
      pix(1'b0, 1'b0, 24'h0, 2);
    end
    pix(1'b1, 1'b0, 24'h0, 2);
    for (int unsigned h = 1; h <= 1400; h++) begin
      pix(1'b0, 1'b0, 24'(h * 7919 + 1), 0);
      if (h == 100 || h == 1000) chk("line5_de", 24'(de1), 24'd0);
      repeat (2) @(negedge clk);
    end
    pix(1'b1, 1'b0, 24'h0, 2);
    for (int unsigned h = 1; h <= 1400; h++) begin
      pix(1'b0, 1'b0, 24'(h * 7919 + 1), 0);
      if (h == 99)   chk("line6_px99_de", 24'(de1), 24'd0);
      if (h == 100) begin
        chk("line6_px100_de",   24'(de1), 24'd1);
        chk("line6_px100_data", d1,       24'(100 * 7919 + 1));
      end
      if (h == 1379) chk("line6_px1379_de", 24'(de1), 24'd1);
      if (h == 1380) begin
        chk("line6_px1380_de",   24'(de1), 24'd0);
        chk("line6_px1380_data", d1,       24'd0);
      end
      repeat (2) @(negedge clk);
    end

    // mode change mid-frame has no effect until the next vsync fall
    mode = 2'd1;
    pix(1'b1, 1'b0, 24'h0, 2);
    for (int unsigned h = 1; h <= 99; h++) pix(1'b0, 1'b0, 24'(h), 2);
    pix(1'b0, 1'b0, 24'h5A5A5A, 0);
    chk("midframe_beat0", d1, 24'h5A5A5A);
    @(negedge clk);
    chk("midframe_idle_data", d1,       24'd0);
    chk("midframe_idle_de",   24'(de1), 24'd1);
    chk("midframe_idle_bf",   24'(bf1), 24'd0);
    repeat (2) @(negedge clk);

    // mode 1, pixel every 2 cycles
    new_frame_to_active();
    pix(1'b0, 1'b0, 24'hABC123, 0);
    chk("m1_beat0",    d1,       24'h000123);
    chk("m1_beat0_bf", 24'(bf1), 24'd1);
    chk("m1_beat0_de", 24'(de1), 24'd1);
    @(negedge clk);
    chk("m1_beat1",    d1,       24'h000ABC);
    chk("m1_beat1_bf", 24'(bf1), 24'd0);
    chk("m1_beat1_de", 24'(de1), 24'd1);
    pix(1'b0, 1'b0, 24'h654321, 0);
    chk("m1_p2_beat0", d1, 24'h000321);
    @(negedge clk);
    chk("m1_p2_beat1", d1,       24'h000654);
    chk("m1_no_ovr",   24'(ov1), 24'd0);
    repeat (2) @(negedge clk);

    // mode 2 triple beat
    mode = 2'd2;
    new_frame_to_active();
    pix(1'b0, 1'b0, 24'h112233, 0);
    chk("m2_beat0", d1, 24'h000033);
    @(negedge clk);
    chk("m2_beat1", d1, 24'h000022);
    @(negedge clk);
    chk("m2_beat2", d1, 24'h000011);
    @(negedge clk);
    chk("m2_idle",  d1, 24'h000000);
    chk("m2_no_ovr", 24'(ov1), 24'd0);

    // mode 2 at 2-cycle pixel spacing overruns; sticky afterwards
    pix(1'b0, 1'b0, 24'hA1B2C3, 0);
    @(negedge clk);
    pix(1'b0, 1'b0, 24'hD4E5F6, 0);
    chk("ovr_set",        24'(ov1), 24'd1);
    chk("ovr_new_beat0",  d1,       24'h0000F6);
    repeat (6) @(negedge clk);
    chk("ovr_sticky",     24'(ov1), 24'd1);
    pix(1'b0, 1'b0, 24'h010203, 4);
    chk("ovr_sticky2",    24'(ov1), 24'd1);

    // mode 3 behaves as 24-bit single beat
    mode = 2'd3;
    new_frame_to_active();
    pix(1'b0, 1'b0, 24'hC0FFEE, 0);
    chk("m3_beat0", d1, 24'hC0FFEE);
    @(negedge clk);
    chk("m3_idle",  d1, 24'h000000);
    repeat (2) @(negedge clk);

    // reset during beat 1 abandons the pixel
    mode = 2'd1;
    new_frame_to_active();
    pix(1'b0, 1'b0, 24'h777888, 0);
    chk("rb_beat0", d1, 24'h000888);
    @(negedge clk);
    chk("rb_beat1", d1, 24'h000777);
    reset = 1'b1;
    @(negedge clk);
    chk("rb_data", d1,       24'd0);
    chk("rb_de",   24'(de1), 24'd0);
    chk("rb_bf",   24'(bf1), 24'd0);
    chk("rb_ovr",  24'(ov1), 24'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rb_after_data", d1,       24'd0);
    chk("rb_after_bf",   24'(bf1), 24'd0);
    pix(1'b0, 1'b0, 24'h123456, 0);
    chk("rb_next_bf",   24'(bf1), 24'd1);
    chk("rb_next_de",   24'(de1), 24'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
